// File: rtl/rv32_pkg.sv
// Shared RV32 constants and the fetch-stage state encoding.
package rv32_pkg;

    localparam int unsigned XLEN    = 32;
    localparam int unsigned FIFO_W  = 2 * XLEN;
    localparam logic [31:0] PC_STEP = 32'd4;
    localparam logic [31:0] NOP     = 32'h0000_0013;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/pc_fetch_if.sv
// Fetch-to-decode valid/ready channel carrying the head entry's PC and instruction.
interface pc_fetch_if;

    logic                       out_valid;
    logic                       out_ready;
    logic [rv32_pkg::XLEN-1:0]  out_pc;
    logic [rv32_pkg::XLEN-1:0]  out_instr;

    modport master (output out_valid, output out_pc, output out_instr, input out_ready);
    modport slave  (input out_valid, input out_pc, input out_instr, output out_ready);

endinterface

// File: rtl/pc_fetch_fifo.sv
// Two-entry register FIFO; entry 0 is always the head so outputs come straight from flops.
module fetch_fifo
    import rv32_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_push,
    input  logic              i_pop,
    input  logic              i_flush,
    input  logic [FIFO_W-1:0] i_data,
    output logic [FIFO_W-1:0] o_data,
    output logic              o_valid,
    output logic [1:0]        o_count
);

    logic [FIFO_W-1:0] r_e0;
    logic [FIFO_W-1:0] r_e1;
    logic [1:0]        r_count;
    logic              w_push;
    logic              w_pop;

    // A push while full is only legal together with a pop.
    assign w_pop  = i_pop && (r_count != 2'd0);
    assign w_push = i_push && ((r_count != 2'd2) || w_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_e0    <= '0;
            r_e1    <= '0;
            r_count <= '0;
        end else if (i_flush) begin
            r_count <= '0;
        end else begin
            case ({w_push, w_pop})
                2'b10: begin
                    if (r_count == 2'd0) r_e0 <= i_data;
                    else                 r_e1 <= i_data;
                    r_count <= r_count + 2'd1;
                end
                2'b01: begin
                    r_e0    <= r_e1;
                    r_count <= r_count - 2'd1;
                end
                2'b11: begin
                    if (r_count == 2'd1) begin
                        r_e0 <= i_data;
                    end else begin
                        r_e0 <= r_e1;
                        r_e1 <= i_data;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_data  = r_e0;
    assign o_valid = (r_count != 2'd0);
    assign o_count = r_count;

endmodule

// File: rtl/pc_fetch.sv
// RV32I fetch stage: PC register, IDLE/RUN/HALT control, redirect/halt handling and retire count.
module pc_fetch
    import rv32_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic [XLEN-1:0] imem_addr,
    input  logic [XLEN-1:0] imem_instr,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            halt_req,
    pc_fetch_if.master      dec,
    output logic            halted,
    output logic            fault,
    output logic [XLEN-1:0] retire_cnt
);

    fetch_state_t     r_state;
    fetch_state_t     w_state_next;
    logic [XLEN-1:0]  r_pc;
    logic [XLEN-1:0]  w_pc_next;
    logic [XLEN-1:0]  r_retire;
    logic             r_fault;
    logic             w_pop;
    logic             w_redir;
    logic             w_misalign;
    logic             w_push;
    logic             w_deq;
    logic [1:0]       w_count;
    logic [FIFO_W-1:0] w_head;

    always_comb begin
        w_pop        = dec.out_valid && dec.out_ready;
        w_redir      = (r_state == RUN) && redirect_valid;
        w_misalign   = (redirect_pc[1:0] != 2'b00);
        // A flush swallows any same-cycle pop, so it is neither dequeued nor retired.
        w_deq        = w_pop && !w_redir;
        w_push       = (r_state == RUN) && !redirect_valid && !halt_req
                       && ((w_count != 2'd2) || w_pop);
        w_pc_next    = r_pc;
        if (w_redir && !w_misalign) w_pc_next = redirect_pc;
        else if (w_push)            w_pc_next = r_pc + PC_STEP;
        w_state_next = r_state;
        unique case (r_state)
            IDLE:    w_state_next = RUN;
            RUN:     if ((w_redir && w_misalign) || halt_req) w_state_next = HALT;
            HALT:    w_state_next = HALT;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_pc     <= RESET_PC;
            r_retire <= '0;
            r_fault  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_pc    <= w_pc_next;
            if (w_deq)                  r_retire <= r_retire + 32'd1;
            if (w_redir && w_misalign)  r_fault  <= 1'b1;
        end
    end

    fetch_fifo u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_pop   (w_deq),
        .i_flush (w_redir),
        .i_data  ({r_pc, imem_instr}),
        .o_data  (w_head),
        .o_valid (dec.out_valid),
        .o_count (w_count)
    );

    assign dec.out_pc    = w_head[FIFO_W-1:XLEN];
    assign dec.out_instr = w_head[XLEN-1:0];
    assign imem_addr     = r_pc;
    assign halted        = (r_state == HALT);
    assign fault         = r_fault;
    assign retire_cnt    = r_retire;

endmodule

// File: doc/pc_fetch.md
# pc_fetch

Instruction fetch stage of the RV32I core. It holds the program counter, drives the byte address into the combinational instruction memory (`imem`), and captures each returned word with its PC into a 2-entry output buffer. Decode pops from that buffer through a valid/ready handshake. Branch/jump redirects flush the buffer, and a halt request or a misaligned redirect target stops fetching.

## Interface
- `RESET_PC`, 32'h0000_0000: PC value loaded on reset.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `imem_addr` out 32: byte address to `imem`; always equal to the PC register.
- `imem_instr` in 32: word returned by `imem` combinationally in the same cycle.
- `redirect_valid` in 1: taken branch/jump this cycle.
- `redirect_pc` in 32: redirect target byte address.
- `halt_req` in 1: stop fetching (ebreak/ecall from the core).
- `out_valid` out 1: buffer head is valid.
- `out_ready` in 1: decode accepts the head this cycle.
- `out_pc` out 32: PC of the head entry.
- `out_instr` out 32: instruction of the head entry.
- `halted` out 1: state is HALT.
- `fault` out 1: sticky; set when a misaligned redirect target is received.
- `retire_cnt` out 32: number of completed out handshakes; wraps modulo 2^32.

## Operation
- **States.** IDLE, RUN, HALT.
  - IDLE→RUN on the first edge after reset release. No fetch occurs in IDLE.
  - RUN→HALT on `halt_req`, or on `redirect_valid` with `redirect_pc[1:0]!=0`.
  - HALT is left only by reset.
- **Push (RUN only).** Happens when no redirect is present and (count<2 or (count==2 and pop)). The entry {pc, `imem_instr`} is written and pc ← pc+4.
- **Pop.** Happens when `out_valid && out_ready`. It drops the head and increments `retire_cnt`.
- **Aligned redirect (RUN).** Flushes the buffer (count←0), sets pc ← `redirect_pc`, and does no push that cycle. Any pop in the same cycle is discarded and does not count toward `retire_cnt`.
- **Misaligned redirect.** Flushes the buffer, leaves pc unchanged, sets `fault`←1, and enters HALT.
- **`halt_req` without redirect.** No push that cycle, enter HALT. Buffered entries still drain normally in HALT.
- **Precedence.** Redirect takes priority over `halt_req`. When both are asserted: flush the buffer, load pc if the target is aligned, then enter HALT.
- **Stall.** When the buffer is full and `out_ready`=0: no push, and pc and `imem_addr` hold.
- **Arithmetic.** pc+4 is 32-bit wrapping (32'hFFFF_FFFC → 0). pc[1:0] is always 0.
- **Reset values.** pc=`RESET_PC`, state=IDLE, count=0, `out_valid`=0, `out_pc`=0, `out_instr`=0, `halted`=0, `fault`=0, `retire_cnt`=0. Asserting reset mid-operation discards all entries immediately (asynchronous).

## Timing
- `imem_addr` comes straight from a register, with no combinational path from any input.
- `out_valid`, `out_pc` and `out_instr` come from buffer registers, with no combinational path from inputs.
- **Fetch latency.** The word at PC p, fetched at edge N, is visible on `out_*` after edge N.
- **After reset.** Edge 1 moves to RUN. Edge 2 pushes `RESET_PC`, so `out_valid`=1 after edge 2.
- **Throughput.** One instruction per cycle when `out_ready` is held high.
- **Redirect.** Asserted at edge N, the first target word appears after edge N+1.
- **Handshake.** `out_pc` and `out_instr` must stay stable while `out_valid`=1 and `out_ready`=0.

## Structure
- Shared package/header `rv32_pkg` holds:
  - state encodings (IDLE=2'd0, RUN=2'd1, HALT=2'd2)
  - XLEN=32
  - the PC step constant 4
  - NOP=32'h0000_0013
- One sub-module, `fetch_fifo`: a 2-entry, 64-bit-wide register FIFO with push, pop, flush and count, where push is accepted while full if pop occurs in the same cycle.
- `pc_fetch` contains the FSM, the PC register, the redirect/halt logic and `retire_cnt`.

## Test plan
- **Reset and stream.** `imem` loaded with program_1.hex, `out_ready`=1. Required: `out_valid` rises after edge 2; the sequence is (0,00000013), (4,00100093), (8,00200113), then one entry per cycle.
- **Backpressure.** `out_ready`=0 for 5 cycles. Required: buffer holds PCs 0 and 4, `imem_addr` stays 8, `out_*` stable. Then `out_ready`=1. Required: 0, 4, 8 are delivered in order with no gap or duplicate.
- **Redirect.** `redirect_pc`=0x28 while the buffer is full and `out_ready`=1. Required: the flush discards the pop (`retire_cnt` unchanged), and the next entry is (0x28, 00a40513) after one edge.
- **Misaligned redirect.** `redirect_pc`=0x3E. Required: `fault`=1, `halted`=1, buffer empty, `imem_addr` unchanged, no further pushes even with `out_ready`=1.
- **Halt drain and wrap.** `halt_req` with 2 entries buffered. Required: both entries drain and `retire_cnt` increments by 2, then `out_valid`=0.
- **Wrap.** Separately, `RESET_PC`=32'hFFFF_FFF8. Required: PCs FFFFFFF8, FFFFFFFC, 00000000.
- **Async reset mid-stream.** `rst_n` low between edges. Required: all outputs return to reset values immediately, then the post-reset sequence restarts from `RESET_PC`.
